// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 field constants and operand class enum for packer/unpacker
package fp_pkg;

  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_EXP_MAX  = 255;
  localparam int FP32_FRAC_W   = 23;
  localparam int MANT_W        = 24;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_t;

endpackage

// File: rtl/fp_unpacker_if.sv
// rtl/fp_unpacker_if.sv - operand-in / unpacked-result-out handshake bundle
interface fp_unpacker_if #(
  parameter int EXP_W = 10
);

  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic signed [EXP_W-1:0] out_exp;
  logic [23:0]             out_frac;
  logic                    out_is_zero;
  logic                    out_is_denorm;
  logic                    out_is_inf;
  logic                    out_is_nan;
  logic                    out_is_snan;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac,
    output out_is_zero, out_is_denorm, out_is_inf, out_is_nan, out_is_snan
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac,
    input  out_is_zero, out_is_denorm, out_is_inf, out_is_nan, out_is_snan
  );

endinterface

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational FP32 field decode into class plus starting exponent/mantissa
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic [31:0]             data,
  output fp_class_t               cls,
  output logic signed [EXP_W-1:0] exp,
  output logic [MANT_W-1:0]       frac
);

  logic [7:0]             field_exp;
  logic [FP32_FRAC_W-1:0] field_frac;

  assign field_exp  = data[30:23];
  assign field_frac = data[22:0];

  always_comb begin
    cls  = NORMAL;
    exp  = $signed({{(EXP_W-8){1'b0}}, field_exp});
    frac = {1'b1, field_frac};
    if (field_exp == 8'd0) begin
      if (field_frac == '0) begin
        cls  = ZERO;
        exp  = '0;
        frac = '0;
      end else begin
        // denormals start at exponent 1 with no hidden bit; the shifter normalises them
        cls  = DENORM;
        exp  = EXP_W'(1);
        frac = {1'b0, field_frac};
      end
    end else if (field_exp == 8'(FP32_EXP_MAX)) begin
      if (field_frac == '0) begin
        cls = INF;
      end else if (field_frac[FP32_FRAC_W-1]) begin
        cls = QNAN;
      end else begin
        cls = SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_unpacker.sv
// rtl/fp_unpacker.sv - FP32 unpacker: classify on accept, normalise denormals one bit per cycle
module fp_unpacker
  import fp_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  fp_unpacker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic                    valid_q, valid_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]       frac_q, frac_d;
  logic                    zero_q, zero_d;
  logic                    denorm_q, denorm_d;
  logic                    inf_q, inf_d;
  logic                    nan_q, nan_d;
  logic                    snan_q, snan_d;

  fp_class_t               cls;
  logic signed [EXP_W-1:0] cls_exp;
  logic [MANT_W-1:0]       cls_frac;
  logic [MANT_W-1:0]       frac_shift;
  logic                    in_ready;
  logic                    accept;
  logic                    load;

  fp_classify #(.EXP_W(EXP_W)) u_classify (
    .data (bus.in_data),
    .cls  (cls),
    .exp  (cls_exp),
    .frac (cls_frac)
  );

  assign in_ready   = ~rst & ((state_q == IDLE) | ((state_q == OUT) & bus.out_ready));
  assign accept     = bus.in_valid & in_ready;
  assign frac_shift = {frac_q[MANT_W-2:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    snan_d   = snan_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        load = accept;
      end
      NORM: begin
        // leave as soon as the shifted-in hidden bit appears so latency is 1+s
        if (frac_q[MANT_W-1]) begin
          state_d = OUT;
          valid_d = 1'b1;
        end else begin
          frac_d = frac_shift;
          exp_d  = exp_q - EXP_W'(1);
          if (frac_shift[MANT_W-1]) begin
            state_d = OUT;
            valid_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (accept) begin
          load = 1'b1;
        end else if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (load) begin
      sign_d   = bus.in_data[31];
      exp_d    = cls_exp;
      frac_d   = cls_frac;
      zero_d   = (cls == ZERO);
      denorm_d = (cls == DENORM);
      inf_d    = (cls == INF);
      nan_d    = (cls == QNAN) | (cls == SNAN);
      snan_d   = (cls == SNAN);
      state_d  = (cls == DENORM) ? NORM : OUT;
      valid_d  = (cls != DENORM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      frac_q   <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
      snan_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
      inf_q    <= inf_d;
      nan_q    <= nan_d;
      snan_q   <= snan_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_sign      = sign_q;
  assign bus.out_exp       = exp_q;
  assign bus.out_frac      = frac_q;
  assign bus.out_is_zero   = zero_q;
  assign bus.out_is_denorm = denorm_q;
  assign bus.out_is_inf    = inf_q;
  assign bus.out_is_nan    = nan_q;
  assign bus.out_is_snan   = snan_q;

endmodule

// File: tb/tb_fp_unpacker.sv
// tb/tb_fp_unpacker.sv - scoreboard bench for fp_unpacker with a value-level FP32 reference model
module tb_fp_unpacker;

  localparam int EXP_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_unpacker_if #(.EXP_W(EXP_W)) bus ();

  fp_unpacker #(.EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sign;
    int          e;
    logic [23:0] f;
    logic [4:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   seen = 0;
  int   seen_cyc = 0;
  bit   rand_ready = 0;
  bit   force_ready = 1;
  int   acc_a[4];

  // flags packed as {zero, denorm, inf, nan, snan}
  function automatic exp_t model(input logic [31:0] d);
    exp_t r;
    int   ef;
    int   ff;
    int   m;
    int   s;
    ef = int'(d[30:23]);
    ff = int'(d[22:0]);
    r.data = d; r.sign = d[31]; r.flags = 5'b0; r.lat = 1; r.acc = 0;
    if (ef == 0 && ff == 0) begin
      r.e = 0; r.f = 24'h0; r.flags = 5'b10000;
    end else if (ef == 0) begin
      m = ff; s = 0;
      while (m < 'h800000) begin
        m = m * 2;
        s++;
      end
      r.e = 1 - s; r.f = m[23:0]; r.flags = 5'b01000; r.lat = 1 + s;
    end else if (ef == 255) begin
      r.e = 255; r.f = 24'(ff + 'h800000);
      if (ff == 0) r.flags = 5'b00100;
      else if (d[22]) r.flags = 5'b00010;
      else r.flags = 5'b00011;
    end else begin
      r.e = ef; r.f = 24'(ff + 'h800000);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit track, output int acc);
    int   tries;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    tries = 0;
    while (!bus.in_ready && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for operand 0x%08h, required 1", d);
      bus.in_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    acc = cyc;
    if (track) begin
      e = model(d);
      e.acc = cyc;
      sb.push_back(e);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
    else bus.out_ready = force_ready;
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      seen = 0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1;
        seen_cyc = cyc;
      end
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: out_valid with empty scoreboard, frac 0x%0h", bus.out_frac);
        end else begin
          m_e = sb.pop_front();
          chk($sformatf("sign[%08h]", m_e.data), 32'(bus.out_sign), 32'(m_e.sign));
          chk($sformatf("exp[%08h]", m_e.data), 32'($signed(bus.out_exp)), 32'(m_e.e));
          chk($sformatf("frac[%08h]", m_e.data), 32'(bus.out_frac), 32'(m_e.f));
          chk($sformatf("flags[%08h]", m_e.data),
              32'({bus.out_is_zero, bus.out_is_denorm, bus.out_is_inf, bus.out_is_nan, bus.out_is_snan}),
              32'(m_e.flags));
          chk($sformatf("latency[%08h]", m_e.data), 32'(seen_cyc - m_e.acc), 32'(m_e.lat));
        end
        seen = 0;
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({nm, "_sign"}, 32'(bus.out_sign), 32'h0);
    chk({nm, "_exp"}, 32'(bus.out_exp), 32'h0);
    chk({nm, "_frac"}, 32'(bus.out_frac), 32'h0);
    chk({nm, "_flags"},
        32'({bus.out_is_zero, bus.out_is_denorm, bus.out_is_inf, bus.out_is_nan, bus.out_is_snan}), 32'h0);
  endtask

  logic [31:0] directed[7];
  logic [31:0] stream4[4];

  initial begin
    int          a;
    logic [31:0] d;
    logic [22:0] f;
    logic        sgn;

    directed = '{32'h3F800000, 32'h00000001, 32'h00400000, 32'h7F800000,
                 32'h7FC00000, 32'h7F800001, 32'h80000000};
    stream4  = '{32'h3F800000, 32'h40490FDB, 32'hC2F60000, 32'h3E99999A};

    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'h1);

    foreach (directed[i]) send(directed[i], 1'b1, a);
    drain();

    force_ready = 1'b0;
    @(negedge clk);
    send(stream4[0], 1'b1, acc_a[0]);
    fork
      begin
        for (int i = 1; i < 4; i++) send(stream4[i], 1'b1, acc_a[i]);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #3;
          chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
          chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
          chk("bp_hold_exp", 32'($signed(bus.out_exp)), 32'd127);
          chk("bp_hold_frac", 32'(bus.out_frac), 32'h800000);
        end
        force_ready = 1'b1;
      end
    join
    chk("bp_stream_gap_12", 32'(acc_a[2] - acc_a[1]), 32'd1);
    chk("bp_stream_gap_23", 32'(acc_a[3] - acc_a[2]), 32'd1);
    drain();

    send(32'h00000001, 1'b0, a);
    repeat (3) @(posedge clk);
    #1;
    chk("norm_in_ready", 32'(bus.in_ready), 32'h0);
    chk("norm_out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("mid_norm_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_norm_reset", 32'(bus.in_ready), 32'h1);
    send(32'h40000000, 1'b1, a);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sgn = 1'($urandom);
      f   = 23'($urandom);
      case ($urandom_range(0, 5))
        0: d = {sgn, 8'h00, 23'h0};
        1: begin
          f = f >> $urandom_range(0, 22);
          if (f == 23'h0) f = 23'h1;
          d = {sgn, 8'h00, f};
        end
        2: d = {sgn, 8'hFF, 23'h0};
        3: begin
          if (f == 23'h0) f = 23'h1;
          d = {sgn, 8'hFF, f};
        end
        default: d = {sgn, 8'($urandom_range(1, 254)), f};
      endcase
      send(d, 1'b1, a);
    end
    rand_ready = 1'b0;
    force_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
